// File: rtl/sarlock_pkg.sv
// Purpose: shared definitions for the SARLock key loader: loader state
//          encoding, default parameter values and the key parity helper
//          used by both the loader datapath and the bench's key model.
// Ports:   none (package).
package sarlock_pkg;

  localparam int KEY_W_DEF       = 8;
  localparam int MAX_FAIL_DEF    = 3;
  localparam int TIMEOUT_CYC_DEF = 64;

  // Widest key the parity helper handles; narrower keys are zero-extended,
  // which leaves their parity unchanged.
  localparam int KEY_W_MAX       = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_LOCKOUT = 3'd4
  } loader_state_e;

  // Returns 1 when key plus parity bit hold an odd number of ones,
  // i.e. the even-parity check failed.
  function automatic logic parity_odd(input logic [KEY_W_MAX-1:0] key,
                                      input logic                 par);
    return (^key) ^ par;
  endfunction

endpackage

// File: rtl/sarlock_key_shreg.sv
// Purpose: serial-in / parallel-out key register. Bits arrive LSB first;
//          write k (0..KEY_W-1) lands in data[k], the write after that is
//          taken as the even-parity bit. Clear has priority over a write.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clear     zero data, parity and bit index
//   i_wr        accept i_bit at the current bit index
//   i_bit       serial bit
//   o_data      assembled key
//   o_cnt       bit index; equals KEY_W once all key bits are in
//   o_par_err   1 when {data, parity} fails the even-parity check
module sarlock_key_shreg
  import sarlock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_wr,
  input  logic                       i_bit,
  output logic [KEY_W-1:0]           o_data,
  output logic [$clog2(KEY_W+1)-1:0] o_cnt,
  output logic                       o_par_err
);

  localparam int CNT_W = $clog2(KEY_W+1);

  logic [KEY_W-1:0] r_data;
  logic             r_parity;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_parity <= 1'b0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_data   <= '0;
      r_parity <= 1'b0;
      r_cnt    <= '0;
    end else if (i_wr) begin
      if (r_cnt == CNT_W'(KEY_W)) begin
        // Index stops at KEY_W; the loader leaves SHIFT on this write.
        r_parity <= i_bit;
      end else begin
        for (int k = 0; k < KEY_W; k++) begin
          if (r_cnt == CNT_W'(k)) r_data[k] <= i_bit;
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_data    = r_data;
  assign o_cnt     = r_cnt;
  assign o_par_err = parity_odd(KEY_W_MAX'(r_data), r_parity);

endmodule

// File: rtl/sarlock_key_loader.sv
// Purpose: key-delivery end of the SARLock key interface. Receives the key
//          serially, checks even parity, and drives the locked netlist's
//          keyinput bus only with a verified key. Repeated failed loads
//          (parity error or inter-bit timeout) force a sticky lockout that
//          only reset clears.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_start     1-cycle request to begin or restart a key load
//   s_valid/s_bit  serial source handshake and data (LSB first, then parity)
//   s_ready        loader accepts s_bit this cycle
//   key_out        key to keyinput[KEY_W-1:0]; 0 unless ARMED
//   key_valid      key_out holds a verified key
//   busy           loader is in SHIFT or CHECK
//   load_err       1-cycle pulse per failed load
//   locked_out     sticky lockout indication
//   dbg_state      current loader state
//   dbg_fail_cnt   consecutive failed-load counter
//
// Serial handshake: a bit transfers on a rising edge where s_valid and
// s_ready are both 1. s_ready is 1 exactly while in SHIFT and does not
// depend on s_valid; the source may hold s_valid low for any number of
// cycles, subject to the inter-bit timeout.
module sarlock_key_loader
  import sarlock_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          s_valid,
  input  logic                          s_bit,
  output logic                          s_ready,
  output logic [KEY_W-1:0]              key_out,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          load_err,
  output logic                          locked_out,
  output loader_state_e                 dbg_state,
  output logic [$clog2(MAX_FAIL+1)-1:0] dbg_fail_cnt
);

  localparam int CNT_W  = $clog2(KEY_W+1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC);
  localparam int FAIL_W = $clog2(MAX_FAIL+1);

  loader_state_e     r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [FAIL_W-1:0] r_fail_cnt;
  logic [KEY_W-1:0]  r_key_out;
  logic              r_key_valid;
  logic              r_load_err;

  logic              w_xfer;
  logic              w_start_ok;
  logic              w_last;
  logic              w_timeout;
  logic              w_fail;
  logic              w_shreg_clear;
  logic [KEY_W-1:0]  w_data;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_par_err;
  logic [FAIL_W-1:0] w_fail_next;
  logic              w_lock_next;

  assign w_xfer     = s_valid && (r_state == ST_SHIFT);
  // load_start is honoured everywhere except CHECK and LOCKOUT.
  assign w_start_ok = load_start &&
                      ((r_state == ST_IDLE) || (r_state == ST_SHIFT) || (r_state == ST_ARMED));
  // A restart coincident with a transfer wins; that bit is dropped.
  assign w_last     = w_xfer && !load_start && (w_cnt == CNT_W'(KEY_W));
  assign w_timeout  = (r_state == ST_SHIFT) && !load_start && !s_valid &&
                      (r_timer == TMR_W'(TIMEOUT_CYC-1));
  assign w_fail     = w_timeout || ((r_state == ST_CHECK) && w_par_err);
  // Every load starts from an empty register, and a failed key never lingers.
  assign w_shreg_clear = w_start_ok || w_fail;

  assign w_fail_next = (r_fail_cnt == FAIL_W'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + 1'b1;
  assign w_lock_next = (w_fail_next == FAIL_W'(MAX_FAIL));

  sarlock_key_shreg #(.KEY_W(KEY_W)) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_shreg_clear),
    .i_wr      (w_xfer),
    .i_bit     (s_bit),
    .o_data    (w_data),
    .o_cnt     (w_cnt),
    .o_par_err (w_par_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_fail_cnt  <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (w_fail) begin
        r_load_err <= 1'b1;
        r_fail_cnt <= w_fail_next;
        r_timer    <= '0;
        r_state    <= w_lock_next ? ST_LOCKOUT : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (load_start) begin
              r_state <= ST_SHIFT;
              r_timer <= '0;
            end
          end
          ST_SHIFT: begin
            if (load_start || w_xfer) begin
              r_timer <= '0;
              if (w_last) r_state <= ST_CHECK;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_CHECK: begin
            // Parity-clean here; the failing case is taken above.
            r_state     <= ST_ARMED;
            r_key_out   <= w_data;
            r_key_valid <= 1'b1;
            r_fail_cnt  <= '0;
          end
          ST_ARMED: begin
            if (load_start) begin
              r_state     <= ST_SHIFT;
              r_timer     <= '0;
              r_key_out   <= '0;
              r_key_valid <= 1'b0;
            end
          end
          ST_LOCKOUT: begin
            r_state <= ST_LOCKOUT;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_ready      = (r_state == ST_SHIFT);
  assign busy         = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
  assign locked_out   = (r_state == ST_LOCKOUT);
  assign key_out      = r_key_out;
  assign key_valid    = r_key_valid;
  assign load_err     = r_load_err;
  assign dbg_state    = r_state;
  assign dbg_fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_sarlock_key_loader.sv
// Directed bench for sarlock_key_loader, ending in a randomly throttled
// load sequence checked against a key scoreboard.
module tb_sarlock_key_loader;
  import sarlock_pkg::*;

  localparam int KEY_W       = 8;
  localparam int MAX_FAIL    = 3;
  localparam int TIMEOUT_CYC = 64;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic load_start = 1'b0;
  logic s_valid    = 1'b0;
  logic s_bit      = 1'b0;

  logic             s_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             load_err;
  logic             locked_out;
  loader_state_e    dbg_state;
  logic [1:0]       dbg_fail_cnt;

  always #5 clk = ~clk;

  sarlock_key_loader #(
    .KEY_W       (KEY_W),
    .MAX_FAIL    (MAX_FAIL),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .s_valid      (s_valid),
    .s_bit        (s_bit),
    .s_ready      (s_ready),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .busy         (busy),
    .load_err     (load_err),
    .locked_out   (locked_out),
    .dbg_state    (dbg_state),
    .dbg_fail_cnt (dbg_fail_cnt)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [KEY_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"},   32'(s_ready),    32'd0);
    check({tag, "_key_out"},   32'(key_out),    32'd0);
    check({tag, "_key_valid"}, 32'(key_valid),  32'd0);
    check({tag, "_busy"},      32'(busy),       32'd0);
    check({tag, "_load_err"},  32'(load_err),   32'd0);
    check({tag, "_locked"},    32'(locked_out), 32'd0);
    check({tag, "_state"},     32'(dbg_state),  32'(ST_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      s_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    check("s_ready_on_bit", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_bit   = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_key(input logic [KEY_W-1:0] key, input logic par, input int gap);
    for (int i = 0; i < KEY_W; i++) send_bit(key[i], gap);
    send_bit(par, gap);
  endtask

  task automatic check_armed(input string tag, input logic [KEY_W-1:0] key);
    check({tag, "_key_valid"}, 32'(key_valid),    32'd1);
    check({tag, "_key_out"},   32'(key_out),      32'(key));
    check({tag, "_load_err"},  32'(load_err),     32'd0);
    check({tag, "_state"},     32'(dbg_state),    32'(ST_ARMED));
    check({tag, "_fail_cnt"},  32'(dbg_fail_cnt), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [KEY_W-1:0] rkey;

    // Reset state, visible before any clock edge.
    #1;
    check_idle_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: good load of 8'h4D, back-to-back bits; key_valid two cycles after parity.
    start_load();
    check("t1_s_ready", 32'(s_ready), 32'd1);
    check("t1_busy",    32'(busy),    32'd1);
    send_key(8'h4D, 1'b0, 0);
    check("t1_check_state", 32'(dbg_state), 32'(ST_CHECK));
    check("t1_check_kv",    32'(key_valid), 32'd0);
    check("t1_check_ready", 32'(s_ready),   32'd0);
    check("t1_check_err",   32'(load_err),  32'd0);
    tick();
    check_armed("t1", 8'h4D);
    check("t1_busy_armed", 32'(busy), 32'd0);

    // 2: bad parity fails once, then a good load clears the fail count.
    start_load();
    send_key(8'h4D, 1'b1, 0);
    check("t2_check_err", 32'(load_err), 32'd0);
    tick();
    check("t2_err",      32'(load_err),     32'd1);
    check("t2_key_out",  32'(key_out),      32'd0);
    check("t2_kv",       32'(key_valid),    32'd0);
    check("t2_state",    32'(dbg_state),    32'(ST_IDLE));
    check("t2_fail_cnt", 32'(dbg_fail_cnt), 32'd1);
    tick();
    check("t2_err_pulse", 32'(load_err), 32'd0);
    start_load();
    send_key(8'h4D, 1'b0, 0);
    tick();
    check_armed("t2_good", 8'h4D);

    // 3: three bad loads in a row lock the loader out until reset.
    for (int n = 1; n <= MAX_FAIL; n++) begin
      start_load();
      send_key(8'h4D, 1'b1, 0);
      tick();
      check("t3_err",      32'(load_err),     32'd1);
      check("t3_fail_cnt", 32'(dbg_fail_cnt), 32'(n));
      check("t3_state",    32'(dbg_state),    (n == MAX_FAIL) ? 32'(ST_LOCKOUT) : 32'(ST_IDLE));
      check("t3_locked",   32'(locked_out),   (n == MAX_FAIL) ? 32'd1 : 32'd0);
      tick();
    end
    load_start = 1'b1;
    s_valid    = 1'b1;
    s_bit      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_lock_ready", 32'(s_ready),    32'd0);
      check("t3_lock_key",   32'(key_out),    32'd0);
      check("t3_lock_state", 32'(dbg_state),  32'(ST_LOCKOUT));
      check("t3_lock_flag",  32'(locked_out), 32'd1);
      check("t3_lock_err",   32'(load_err),   32'd0);
    end
    load_start = 1'b0;
    s_valid    = 1'b0;
    rst_n      = 1'b0;
    #2;
    check_idle_outputs("t3_reset");
    check("t3_reset_fail", 32'(dbg_fail_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 4: inter-bit timeout after TIMEOUT_CYC idle cycles; TIMEOUT_CYC-1 gaps are fine.
    start_load();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
    check("t4_pre_state", 32'(dbg_state), 32'(ST_SHIFT));
    check("t4_pre_err",   32'(load_err),  32'd0);
    tick();
    check("t4_err",      32'(load_err),     32'd1);
    check("t4_state",    32'(dbg_state),    32'(ST_IDLE));
    check("t4_fail_cnt", 32'(dbg_fail_cnt), 32'd1);
    start_load();
    send_key(8'h3C, 1'b0, TIMEOUT_CYC - 1);
    tick();
    check_armed("t4_gap", 8'h3C);

    // 5: reload from ARMED drops the key at once; restart mid-load is not a failure.
    start_load();
    send_key(8'h4D, 1'b0, 0);
    tick();
    check_armed("t5_first", 8'h4D);
    start_load();
    check("t5_drop_kv",    32'(key_valid), 32'd0);
    check("t5_drop_key",   32'(key_out),   32'd0);
    check("t5_drop_state", 32'(dbg_state), 32'(ST_SHIFT));
    send_key(8'hA7, 1'b1, 0);
    tick();
    check_armed("t5_a7", 8'hA7);
    start_load();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    load_start = 1'b1;
    s_valid    = 1'b1;
    s_bit      = 1'b1;
    tick();
    load_start = 1'b0;
    s_valid    = 1'b0;
    check("t5_restart_state", 32'(dbg_state),    32'(ST_SHIFT));
    check("t5_restart_err",   32'(load_err),     32'd0);
    check("t5_restart_fail",  32'(dbg_fail_cnt), 32'd0);
    send_key(8'h4D, 1'b0, 0);
    check("t5_restart_check", 32'(dbg_state), 32'(ST_CHECK));
    tick();
    check_armed("t5_restart", 8'h4D);

    // 6: asynchronous reset mid-SHIFT and while ARMED.
    start_load();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst_shift");
    #1 rst_n = 1'b1;
    tick();
    start_load();
    send_key(8'h4D, 1'b0, 0);
    tick();
    check_armed("t6_pre", 8'h4D);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst_armed");
    #1 rst_n = 1'b1;
    tick();

    // 6: randomly throttled loads against the key scoreboard.
    for (int n = 0; n < 1000; n++) begin
      rkey = KEY_W'($urandom);
      exp_q.push_back(rkey);
      start_load();
      for (int i = 0; i < KEY_W; i++) send_bit(rkey[i], $urandom_range(0, 3));
      send_bit(parity_odd(KEY_W_MAX'(rkey), 1'b0), $urandom_range(0, 3));
      tick();
      check("rand_key_valid", 32'(key_valid), 32'd1);
      check("rand_key_out",   32'(key_out),   32'(exp_q.pop_front()));
      check("rand_load_err",  32'(load_err),  32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
